// File: rtl/dma_bus_master.sv
// dma_bus_master: byte-wide DMA copy/fill engine that owns the data bus while busy
// and passes CPU accesses straight through to memory while idle.
module dma_bus_master #(
  parameter logic [7:0] DMA_ADDRESS = 8'h13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cpu_din,
  input  logic [15:0] cpu_address,
  input  logic        cpu_w_en,
  input  logic        cpu_r_en,
  output logic [7:0]  cpu_dout,
  output logic        cpu_stall,
  output logic [7:0]  mem_din,
  output logic [15:0] mem_address,
  output logic        mem_w_en,
  output logic        mem_r_en,
  input  logic [7:0]  mem_dout,
  output logic        done_flag,
  input  logic        done_flag_clr
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t      state_q;
  logic [15:0] src_q, dst_q, off16;
  logic [7:0]  len_q, rdata_q, rd_val;
  logic [2:0]  off;
  logic        fill_q, done_q, busy, sel, reg_wr, start;
  assign off16     = cpu_address - {8'h10, DMA_ADDRESS};
  assign sel       = off16 < 16'd6;
  assign off       = off16[2:0];
  assign busy      = state_q != IDLE;
  assign reg_wr    = !busy && cpu_w_en && sel;
  assign start     = reg_wr && off == 3'd5 && cpu_din[0];
  assign cpu_stall = busy;
  assign done_flag = done_q;
  assign cpu_dout  = busy ? 8'h00 : (mem_dout | rdata_q);
  // In DONE the strobes are low, so the address value there is irrelevant.
  assign mem_address = busy ? (state_q == RD ? src_q : dst_q) : cpu_address;
  assign mem_r_en    = busy ? state_q == RD : cpu_r_en;
  assign mem_w_en    = busy ? state_q == WR : cpu_w_en;
  assign mem_din     = busy ? (fill_q ? src_q[7:0] : mem_dout) : cpu_din;
  always_comb
    rd_val = off == 3'd0 ? src_q[7:0] :
             off == 3'd1 ? src_q[15:8] :
             off == 3'd2 ? dst_q[7:0] :
             off == 3'd3 ? dst_q[15:8] :
             off == 3'd4 ? len_q :
             {busy, done_q, 4'b0000, fill_q, 1'b0};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      rdata_q <= '0;
      fill_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rdata_q <= (!busy && cpu_r_en && sel) ? rd_val : 8'h00;
      if (state_q == DONE) done_q <= 1'b1;
      else if (start || done_flag_clr) done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (reg_wr)
            case (off)
              3'd0: src_q[7:0]  <= cpu_din;
              3'd1: src_q[15:8] <= cpu_din;
              3'd2: dst_q[7:0]  <= cpu_din;
              3'd3: dst_q[15:8] <= cpu_din;
              3'd4: len_q       <= cpu_din;
              default: begin
                fill_q <= cpu_din[1];
                if (cpu_din[0]) state_q <= len_q == 8'd0 ? DONE : cpu_din[1] ? WR : RD;
              end
            endcase
        RD: state_q <= WR;
        WR: begin
          dst_q   <= dst_q + 16'd1;
          len_q   <= len_q - 8'd1;
          if (!fill_q) src_q <= src_q + 16'd1;
          state_q <= len_q == 8'd1 ? DONE : fill_q ? WR : RD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_bus_master.sv
// tb_dma_bus_master: directed tests with a transaction-level bus model checked every cycle.
module tb_dma_bus_master;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  cpu_din = '0, cpu_dout, mem_din, mem_dout = '0;
  logic [15:0] cpu_address = '0, mem_address;
  logic        cpu_w_en = 1'b0, cpu_r_en = 1'b0, cpu_stall, mem_w_en, mem_r_en;
  logic        done_flag, done_flag_clr = 1'b0;
  int          tests = 0, fails = 0;

  dma_bus_master dut (
    .clk(clk), .rst(rst), .cpu_din(cpu_din), .cpu_address(cpu_address),
    .cpu_w_en(cpu_w_en), .cpu_r_en(cpu_r_en), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .mem_din(mem_din), .mem_address(mem_address), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
    .mem_dout(mem_dout), .done_flag(done_flag), .done_flag_clr(done_flag_clr)
  );

  always #5 clk = ~clk;

  // d_ram_and_io stand-in: the io page 0x10xx reads back as 0
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_address] <= mem_din;
    mem_dout <= (mem_r_en && mem_address[15:8] != 8'h10) ? mem[mem_address] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected bus operations of a transfer, produced as a list when START is seen
  typedef struct {logic r, w, d; logic [15:0] a; logic [7:0] v;} op_t;
  op_t         q[$];
  op_t         op;
  bit   [7:0]  ref_mem [0:65535];
  logic [15:0] msrc = '0, mdst = '0;
  logic [7:0]  mlen = '0, exp_rd = '0;
  logic        mfill = 1'b0, mdone = 1'b0, nd, is_done;

  function automatic logic [7:0] reg_val(input logic [2:0] k);
    case (k)
      3'd0: return msrc[7:0];
      3'd1: return msrc[15:8];
      3'd2: return mdst[7:0];
      3'd3: return mdst[15:8];
      3'd4: return mlen;
      default: return {2'b00, mdone, 3'b000, mfill, 1'b0} << 0 & 8'h42 | {1'b0, mdone, 6'b0} | {6'b0, mfill, 1'b0};
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      q.delete();
      msrc = '0; mdst = '0; mlen = '0; mfill = 1'b0; mdone = 1'b0; exp_rd = '0;
      chk("rst_stall", {31'b0, cpu_stall}, 0);
      chk("rst_done", {31'b0, done_flag}, 0);
    end else begin
      chk("done_flag", {31'b0, done_flag}, {31'b0, mdone});
      chk("cpu_dout", {24'b0, cpu_dout}, {24'b0, exp_rd});
      exp_rd = '0;
      nd = mdone;
      is_done = 1'b0;
      if (q.size() != 0) begin
        op = q.pop_front();
        chk("busy_stall", {31'b0, cpu_stall}, 1);
        chk("busy_r_en", {31'b0, mem_r_en}, {31'b0, op.r});
        chk("busy_w_en", {31'b0, mem_w_en}, {31'b0, op.w});
        if (!op.d) chk("busy_addr", {16'b0, mem_address}, {16'b0, op.a});
        if (op.w) chk("busy_din", {24'b0, mem_din}, {24'b0, op.v});
        is_done = op.d;
      end else begin
        chk("idle_stall", {31'b0, cpu_stall}, 0);
        chk("pass_addr", {16'b0, mem_address}, {16'b0, cpu_address});
        chk("pass_r_en", {31'b0, mem_r_en}, {31'b0, cpu_r_en});
        chk("pass_w_en", {31'b0, mem_w_en}, {31'b0, cpu_w_en});
        chk("pass_din", {24'b0, mem_din}, {24'b0, cpu_din});
        if (cpu_r_en)
          exp_rd = (cpu_address >= 16'h1013 && cpu_address <= 16'h1018) ? reg_val(3'(cpu_address - 16'h1013)) :
                   cpu_address[15:8] == 8'h10 ? 8'h00 : ref_mem[cpu_address];
        if (cpu_w_en) begin
          ref_mem[cpu_address] = cpu_din;
          case (cpu_address)
            16'h1013: msrc[7:0] = cpu_din;
            16'h1014: msrc[15:8] = cpu_din;
            16'h1015: mdst[7:0] = cpu_din;
            16'h1016: mdst[15:8] = cpu_din;
            16'h1017: mlen = cpu_din;
            16'h1018: begin
              mfill = cpu_din[1];
              if (cpu_din[0]) begin
                nd = 1'b0;
                for (int i = 0; i < mlen; i++) begin
                  if (mfill) q.push_back('{1'b0, 1'b1, 1'b0, mdst, msrc[7:0]});
                  else begin
                    q.push_back('{1'b1, 1'b0, 1'b0, msrc, 8'h00});
                    q.push_back('{1'b0, 1'b1, 1'b0, mdst, ref_mem[msrc]});
                    ref_mem[mdst] = ref_mem[msrc];
                    msrc++;
                  end
                  if (mfill) ref_mem[mdst] = msrc[7:0];
                  mdst++;
                end
                q.push_back('{1'b0, 1'b0, 1'b1, 16'h0, 8'h00});
                mlen = '0;
              end
            end
            default: ;
          endcase
        end
      end
      if (is_done) nd = 1'b1;
      else if (done_flag_clr) nd = 1'b0;
      mdone = nd;
    end
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_address = a; cpu_din = d; cpu_w_en = 1'b1;
    @(posedge clk); #1;
    cpu_w_en = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [15:0] a, input logic [7:0] exp);
    cpu_address = a; cpu_r_en = 1'b1;
    @(posedge clk); #1;
    cpu_r_en = 1'b0;
    chk(name, {24'b0, cpu_dout}, {24'b0, exp});
  endtask

  task automatic run(output int n, output int rc);
    n = 0; rc = 0;
    while (cpu_stall && n < 100) begin
      if (mem_r_en) rc++;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("busy_timeout", 1, 0);
  endtask

  task automatic pulse_clr();
    done_flag_clr = 1'b1;
    @(posedge clk); #1;
    done_flag_clr = 1'b0;
  endtask

  int n, rc;
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rdchk("reset_ctrl", 16'h1018, 8'h00);
    rdchk("reset_len", 16'h1017, 8'h00);
    // 1: copy four bytes from d_ram into VRAM
    for (int i = 0; i < 4; i++) wr(16'h0100 + 16'(i), 8'hA1 + 8'(i));
    wr(16'h1013, 8'h00); wr(16'h1014, 8'h01);
    wr(16'h1015, 8'h00); wr(16'h1016, 8'h20);
    wr(16'h1017, 8'h04); wr(16'h1018, 8'h01);
    run(n, rc);
    chk("copy_stall_cycles", n, 9);
    chk("copy_reads", rc, 4);
    chk("copy_done", {31'b0, done_flag}, 1);
    rdchk("copy_len", 16'h1017, 8'h00);
    rdchk("copy_src_l", 16'h1013, 8'h04);
    rdchk("copy_src_h", 16'h1014, 8'h01);
    rdchk("copy_ctrl", 16'h1018, 8'h40);
    for (int i = 0; i < 4; i++) rdchk("copy_vram", 16'h2000 + 16'(i), 8'hA1 + 8'(i));
    // 2: fill three bytes with 0x5A
    wr(16'h1013, 8'h5A); wr(16'h1015, 8'h00); wr(16'h1016, 8'h02);
    wr(16'h1017, 8'h03); wr(16'h1018, 8'h03);
    run(n, rc);
    chk("fill_stall_cycles", n, 4);
    chk("fill_reads", rc, 0);
    for (int i = 0; i < 3; i++) rdchk("fill_data", 16'h0200 + 16'(i), 8'h5A);
    rdchk("fill_ctrl", 16'h1018, 8'h42);
    // 3: LEN=0 after clearing done_flag while idle
    pulse_clr();
    chk("clr_idle", {31'b0, done_flag}, 0);
    wr(16'h1017, 8'h00); wr(16'h1018, 8'h01);
    run(n, rc);
    chk("len0_stall_cycles", n, 1);
    chk("len0_done", {31'b0, done_flag}, 1);
    // 4: destination wraps 0xFFFF -> 0x0000
    wr(16'h1013, 8'h3C); wr(16'h1015, 8'hFF); wr(16'h1016, 8'hFF);
    wr(16'h1017, 8'h02); wr(16'h1018, 8'h03);
    run(n, rc);
    chk("wrap_stall_cycles", n, 3);
    rdchk("wrap_ffff", 16'hFFFF, 8'h3C);
    rdchk("wrap_0000", 16'h0000, 8'h3C);
    rdchk("wrap_dst_l", 16'h1015, 8'h01);
    rdchk("wrap_dst_h", 16'h1016, 8'h00);
    // 5: reset in the third busy cycle of an 8-byte copy
    wr(16'h1013, 8'h00); wr(16'h1014, 8'h03);
    wr(16'h1015, 8'h00); wr(16'h1016, 8'h21);
    wr(16'h1017, 8'h08); wr(16'h1018, 8'h01);
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_busy_before", {31'b0, cpu_stall}, 1);
    rst = 1'b0;
    #1;
    chk("abort_stall", {31'b0, cpu_stall}, 0);
    chk("abort_done", {31'b0, done_flag}, 0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) rdchk("abort_regs", 16'h1013 + 16'(i), 8'h00);
    wr(16'h0400, 8'h77);
    rdchk("abort_passthru", 16'h0400, 8'h77);
    // 6: clear during DONE loses, a later clear wins
    wr(16'h1018, 8'h01);
    done_flag_clr = 1'b1;
    @(posedge clk); #1;
    done_flag_clr = 1'b0;
    chk("clr_in_done", {31'b0, done_flag}, 1);
    pulse_clr();
    chk("clr_after", {31'b0, done_flag}, 0);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
